// File: rtl/uc_multicycle_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: opcodes, ALU codes,
// the FSM state enum and the opcode class used for DECODE dispatch.
package uc_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_SUBN  = 3'b110;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I,
        MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP
    } state_e;

    typedef enum logic [2:0] {K_R, K_I, K_MEM, K_BR, K_J, K_BAD} op_kind_e;

endpackage

// File: rtl/uc_multicycle_if.sv
// Control-unit bus: opcode/mem_ready in from the datapath, strobes and debug
// state out. The control unit uses the slave modport.
interface uc_multicycle_if #(
    parameter int OPCODE_W = 6,
    parameter int ALUC_W   = 3,
    parameter int STATE_W  = 4
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                pc_we, ir_we, en, memreg, enw, enr;
    logic                en_mult2, en_mult3, branch, jump, illegal;
    logic [ALUC_W-1:0]   aluc;
    logic [STATE_W-1:0]  state_o;

    modport master (
        output opcode, mem_ready,
        input  pc_we, ir_we, en, memreg, enw, enr, en_mult2, en_mult3,
               branch, jump, illegal, aluc, state_o
    );

    modport slave (
        input  opcode, mem_ready,
        output pc_we, ir_we, en, memreg, enw, enr, en_mult2, en_mult3,
               branch, jump, illegal, aluc, state_o
    );
endinterface

// File: rtl/uc_multicycle_out_decode.sv
// Strobe decoder: (state, latched opcode) -> datapath controls. illegal and the
// FETCH pc_we are the only terms that look at live inputs (DECODE opcode, mem_go).
module uc_out_decode
    import uc_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUC_W   = 3
) (
    input  state_e              state_i,
    input  logic [OPCODE_W-1:0] op_q_i,
    input  logic                bad_op_i,
    input  logic                mem_go_i,
    output logic                pc_we_o,
    output logic                ir_we_o,
    output logic                en_o,
    output logic                memreg_o,
    output logic                enw_o,
    output logic                enr_o,
    output logic                en_mult2_o,
    output logic                en_mult3_o,
    output logic                branch_o,
    output logic                jump_o,
    output logic                illegal_o,
    output logic [ALUC_W-1:0]   aluc_o
);
    logic [2:0] alu_imm;

    always_comb begin
        alu_imm = ALU_ADD;
        if (op_q_i == OPCODE_W'(OP_ANDI))      alu_imm = ALU_AND;
        else if (op_q_i == OPCODE_W'(OP_ORI))  alu_imm = ALU_OR;
        else if (op_q_i == OPCODE_W'(OP_SLTI)) alu_imm = ALU_SLT;
    end

    always_comb begin
        pc_we_o    = 1'b0;
        ir_we_o    = 1'b0;
        en_o       = 1'b0;
        memreg_o   = 1'b0;
        enw_o      = 1'b0;
        enr_o      = 1'b0;
        en_mult2_o = 1'b0;
        en_mult3_o = 1'b0;
        branch_o   = 1'b0;
        jump_o     = 1'b0;
        illegal_o  = 1'b0;
        aluc_o     = ALUC_W'(ALU_ADD);
        case (state_i)
            FETCH: begin
                enr_o   = 1'b1;
                ir_we_o = 1'b1;
                pc_we_o = mem_go_i;
            end
            DECODE:   illegal_o = bad_op_i;
            EXEC_R:   aluc_o = ALUC_W'(ALU_FUNCT);
            WB_R: begin
                en_o       = 1'b1;
                memreg_o   = 1'b1;
                en_mult3_o = 1'b1;
            end
            EXEC_I: begin
                en_mult2_o = 1'b1;
                aluc_o     = ALUC_W'(alu_imm);
            end
            WB_I: begin
                en_o     = 1'b1;
                memreg_o = 1'b1;
            end
            MEM_ADDR: en_mult2_o = 1'b1;
            MEM_RD:   enr_o = 1'b1;
            MEM_WB:   en_o = 1'b1;
            MEM_WR:   enw_o = 1'b1;
            BRANCH: begin
                branch_o = 1'b1;
                pc_we_o  = 1'b1;
                aluc_o   = (op_q_i == OPCODE_W'(OP_BNE)) ? ALUC_W'(ALU_SUBN)
                                                         : ALUC_W'(ALU_SUB);
            end
            JUMP: begin
                jump_o  = 1'b1;
                pc_we_o = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/uc_multicycle.sv
// Multi-cycle MIPS control unit: state register, opcode latch and sequencing.
// Define UCM_MEM_WAIT_EN to make FETCH/MEM_RD/MEM_WR wait for mem_ready.
module uc_multicycle
    import uc_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUC_W   = 3,
    parameter int STATE_W  = 4
) (
    input logic            clk,
    input logic            rst,
    uc_multicycle_if.slave bus
);
    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    op_kind_e            kind;
    logic                mem_go;

`ifdef UCM_MEM_WAIT_EN
    assign mem_go = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign mem_go = 1'b1;
`endif

    always_comb begin
        kind = K_BAD;
        if (bus.opcode == OPCODE_W'(OP_R))
            kind = K_R;
        else if (bus.opcode == OPCODE_W'(OP_ADDI) || bus.opcode == OPCODE_W'(OP_ANDI) ||
                 bus.opcode == OPCODE_W'(OP_ORI)  || bus.opcode == OPCODE_W'(OP_SLTI))
            kind = K_I;
        else if (bus.opcode == OPCODE_W'(OP_LW) || bus.opcode == OPCODE_W'(OP_SW))
            kind = K_MEM;
        else if (bus.opcode == OPCODE_W'(OP_BEQ) || bus.opcode == OPCODE_W'(OP_BNE))
            kind = K_BR;
        else if (bus.opcode == OPCODE_W'(OP_J))
            kind = K_J;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: if (mem_go) state_d = DECODE;
            DECODE: begin
                op_d = bus.opcode;
                case (kind)
                    K_R:     state_d = EXEC_R;
                    K_I:     state_d = EXEC_I;
                    K_MEM:   state_d = MEM_ADDR;
                    K_BR:    state_d = BRANCH;
                    K_J:     state_d = JUMP;
                    default: state_d = FETCH;  // undefined opcode: skip, PC already advanced
                endcase
            end
            EXEC_R:   state_d = WB_R;
            WB_R:     state_d = FETCH;
            EXEC_I:   state_d = WB_I;
            WB_I:     state_d = FETCH;
            MEM_ADDR: state_d = (op_q == OPCODE_W'(OP_LW)) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_go) state_d = MEM_WB;
            MEM_WB:   state_d = FETCH;
            MEM_WR:   if (mem_go) state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JUMP:     state_d = FETCH;
            default:  state_d = IDLE;
        endcase
    end

    assign bus.state_o = STATE_W'(state_q);

    uc_out_decode #(
        .OPCODE_W (OPCODE_W),
        .ALUC_W   (ALUC_W)
    ) u_out_decode (
        .state_i    (state_q),
        .op_q_i     (op_q),
        .bad_op_i   (kind == K_BAD),
        .mem_go_i   (mem_go),
        .pc_we_o    (bus.pc_we),
        .ir_we_o    (bus.ir_we),
        .en_o       (bus.en),
        .memreg_o   (bus.memreg),
        .enw_o      (bus.enw),
        .enr_o      (bus.enr),
        .en_mult2_o (bus.en_mult2),
        .en_mult3_o (bus.en_mult3),
        .branch_o   (bus.branch),
        .jump_o     (bus.jump),
        .illegal_o  (bus.illegal),
        .aluc_o     (bus.aluc)
    );
endmodule

// File: tb/tb_uc_multicycle.sv
// Bench for uc_multicycle: per-instruction strobe sequences from an instruction-level
// reference table, directed scenarios plus randomized opcode streams.
module tb_uc_multicycle;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uc_multicycle_if bus ();
    uc_multicycle dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    // strobe word: pc_we ir_we en memreg enw enr en_mult2 en_mult3 branch jump illegal aluc[2:0]
    localparam logic [13:0] B_PC  = 14'h2000;
    localparam logic [13:0] B_IR  = 14'h1000;
    localparam logic [13:0] B_EN  = 14'h0800;
    localparam logic [13:0] B_MR  = 14'h0400;
    localparam logic [13:0] B_ENW = 14'h0200;
    localparam logic [13:0] B_ENR = 14'h0100;
    localparam logic [13:0] B_M2  = 14'h0080;
    localparam logic [13:0] B_M3  = 14'h0040;
    localparam logic [13:0] B_BR  = 14'h0020;
    localparam logic [13:0] B_J   = 14'h0010;
    localparam logic [13:0] B_ILL = 14'h0008;

    logic [13:0] exp_q[$];
    logic [5:0]  legal_ops[10] = '{6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b001010,
                                   6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010};

    function automatic logic [13:0] obs();
        return {bus.pc_we, bus.ir_we, bus.en, bus.memreg, bus.enw, bus.enr, bus.en_mult2,
                bus.en_mult3, bus.branch, bus.jump, bus.illegal, bus.aluc};
    endfunction

    // Expected strobes cycle by cycle, FETCH up to (not including) the next FETCH.
    function automatic void build_expect(input logic [5:0] op);
        exp_q.delete();
        exp_q.push_back(B_PC | B_IR | B_ENR);
        case (op)
            6'b000000: begin exp_q.push_back(14'h0); exp_q.push_back(14'd2);
                             exp_q.push_back(B_EN | B_MR | B_M3); end
            6'b001000: begin exp_q.push_back(14'h0); exp_q.push_back(B_M2 | 14'd0);
                             exp_q.push_back(B_EN | B_MR); end
            6'b001100: begin exp_q.push_back(14'h0); exp_q.push_back(B_M2 | 14'd3);
                             exp_q.push_back(B_EN | B_MR); end
            6'b001101: begin exp_q.push_back(14'h0); exp_q.push_back(B_M2 | 14'd4);
                             exp_q.push_back(B_EN | B_MR); end
            6'b001010: begin exp_q.push_back(14'h0); exp_q.push_back(B_M2 | 14'd5);
                             exp_q.push_back(B_EN | B_MR); end
            6'b100011: begin exp_q.push_back(14'h0); exp_q.push_back(B_M2);
                             exp_q.push_back(B_ENR); exp_q.push_back(B_EN); end
            6'b101011: begin exp_q.push_back(14'h0); exp_q.push_back(B_M2);
                             exp_q.push_back(B_ENW); end
            6'b000100: begin exp_q.push_back(14'h0); exp_q.push_back(B_BR | B_PC | 14'd1); end
            6'b000101: begin exp_q.push_back(14'h0); exp_q.push_back(B_BR | B_PC | 14'd6); end
            6'b000010: begin exp_q.push_back(14'h0); exp_q.push_back(B_J | B_PC); end
            default:   exp_q.push_back(B_ILL);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic next_mem_ready();
`ifdef UCM_MEM_WAIT_EN
        return 1'b1;
`else
        return 1'($urandom_range(0, 1));
`endif
    endfunction

    // Entered while sampling FETCH; leaves while sampling the following FETCH.
    task automatic run_instr(input logic [5:0] op, input string tag);
        bus.opcode = op;
        bus.mem_ready = next_mem_ready();
        #0;
        build_expect(op);
        checks++;
        if (bus.state_o !== 4'd1) begin
            failures++;
            $display("FAIL %s_start op=%b state got %0d expected 1", tag, op, bus.state_o);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs() !== exp_q[i]) begin
                failures++;
                $display("FAIL %s op=%b cycle %0d strobes got %b expected %b",
                         tag, op, i, obs(), exp_q[i]);
            end
            if (i >= 2) bus.opcode = 6'($urandom);
            bus.mem_ready = next_mem_ready();
            step();
        end
        checks++;
        if (bus.state_o !== 4'd1) begin
            failures++;
            $display("FAIL %s_latency op=%b state got %0d expected 1 after %0d cycles",
                     tag, op, bus.state_o, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.opcode = 6'b000000;
        bus.mem_ready = 1'b1;
        repeat (3) begin
            step();
            checks++;
            if (obs() !== 14'h0 || bus.state_o !== 4'd0) begin
                failures++;
                $display("FAIL reset_hold strobes got %b state %0d expected 0 and 0",
                         obs(), bus.state_o);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs() !== 14'h0 || bus.state_o !== 4'd0) begin
            failures++;
            $display("FAIL reset_idle strobes got %b state %0d expected 0 and 0",
                     obs(), bus.state_o);
        end
        step();
    endtask

    task automatic test_r_type();
        run_instr(6'b000000, "r_type");
    endtask

    task automatic test_i_type();
        run_instr(6'b001000, "addi");
        run_instr(6'b001100, "andi");
        run_instr(6'b001101, "ori");
        run_instr(6'b001010, "slti");
    endtask

    task automatic test_mem();
        run_instr(6'b100011, "lw");
        run_instr(6'b101011, "sw");
    endtask

    task automatic test_branch_jump();
        run_instr(6'b000100, "beq");
        run_instr(6'b000101, "bne");
        run_instr(6'b000010, "j");
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, "illegal_ff");
        run_instr(6'b000001, "illegal_01");
    endtask

    task automatic test_back_to_back();
        logic [5:0] op;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom);
            else op = legal_ops[$urandom_range(0, 9)];
            run_instr(op, "random");
        end
    endtask

    task automatic test_rst_mid();
        bus.opcode = 6'b100011;
        bus.mem_ready = 1'b1;
        repeat (4) step();
        checks++;
        if (bus.state_o !== 4'd9 || bus.en !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre state got %0d en %b expected 9 and 1", bus.state_o, bus.en);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.state_o !== 4'd0 || bus.en !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_async state got %0d en %b expected 0 and 0", bus.state_o, bus.en);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (obs() !== 14'h0 || bus.state_o !== 4'd0) begin
            failures++;
            $display("FAIL rst_mid_idle strobes got %b state %0d expected 0 and 0",
                     obs(), bus.state_o);
        end
        step();
        run_instr(6'b000000, "after_rst");
    endtask

    task automatic test_mem_wait();
        int pulses = 0;
        bus.opcode = 6'b000010;
`ifdef UCM_MEM_WAIT_EN
        for (int c = 0; c < 4; c++) begin
            bus.mem_ready = 1'b0;
            #1;
            checks++;
            if (bus.state_o !== 4'd1 || obs() !== (B_IR | B_ENR)) begin
                failures++;
                $display("FAIL wait_hold cycle %0d state %0d strobes %b expected 1 and %b",
                         c, bus.state_o, obs(), B_IR | B_ENR);
            end
            if (bus.pc_we === 1'b1) pulses++;
            step();
        end
`endif
        bus.mem_ready = 1'b1;
        #1;
        if (bus.pc_we === 1'b1) pulses++;
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL wait_pc_pulses got %0d expected 1", pulses);
        end
        step();
        checks++;
        if (bus.state_o !== 4'd2) begin
            failures++;
            $display("FAIL wait_release state got %0d expected 2", bus.state_o);
        end
        repeat (2) step();
        checks++;
        if (bus.state_o !== 4'd1) begin
            failures++;
            $display("FAIL wait_return state got %0d expected 1", bus.state_o);
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_i_type();
        test_mem();
        test_branch_jump();
        test_illegal();
        test_back_to_back();
        test_rst_mid();
        test_mem_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
